// File: rtl/distributor.sv
// Word-to-byte distributor: accepts 64-bit packet words and emits them byte by byte,
// tracking packet framing, flagging out-of-sequence words and counting completed packets.
`ifndef PFW_SZ
`define PFW_SZ 64
`endif
`ifndef PCC_DATA
`define PCC_DATA 2'd0
`endif
`ifndef PCC_SOP
`define PCC_SOP 2'd1
`endif
`ifndef PCC_EOP
`define PCC_EOP 2'd2
`endif
`ifndef PCC_BADEOP
`define PCC_BADEOP 2'd3
`endif

module distributor (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_srdy,
  output logic               p_drdy,
  input  logic [`PFW_SZ-1:0] p_data,
  input  logic [1:0]         p_code,
  input  logic [2:0]         p_nbytes,
  output logic               c_srdy,
  input  logic               c_drdy,
  output logic [7:0]         c_data,
  output logic [1:0]         c_code,
  output logic               err_seq,
  output logic [15:0]        pkt_cnt
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [`PFW_SZ-1:0] word_q, word_d;
  logic [1:0]         wcode_q, wcode_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         idx_q, idx_d;
  logic               in_pkt_q, in_pkt_d;
  logic               c_srdy_q, c_srdy_d;
  logic [7:0]         c_data_q, c_data_d;
  logic [1:0]         c_code_q, c_code_d;
  logic               err_seq_q, err_seq_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;

  logic       p_xfer, c_xfer, last_byte, word_ok;
  logic [2:0] p_last;

  // Byte 0 lives in the most significant byte of the word.
  function automatic logic [7:0] byte_sel(input logic [`PFW_SZ-1:0] w, input logic [2:0] i);
    logic [`PFW_SZ-1:0] s;
    s = w << {i, 3'b000};
    return s[`PFW_SZ-1 -: 8];
  endfunction

  function automatic logic [1:0] byte_code(input logic [1:0] code, input logic [2:0] i,
                                           input logic [2:0] last);
    logic [1:0] r;
    r = `PCC_DATA;
    if (code == `PCC_SOP && i == 3'd0) r = `PCC_SOP;
    else if (i == last && (code == `PCC_EOP || code == `PCC_BADEOP)) r = code;
    return r;
  endfunction

  always_comb begin
    last_byte = (idx_q == last_q);
    p_drdy    = reset & ((state_q == StIdle) | ((state_q == StSend) & c_drdy & last_byte));
    p_xfer    = p_srdy & p_drdy;
    c_xfer    = c_srdy_q & c_drdy;
    word_ok   = (p_code == `PCC_SOP) | in_pkt_q;
    if ((p_code == `PCC_EOP || p_code == `PCC_BADEOP) && p_nbytes != 3'd0) begin
      p_last = p_nbytes - 3'd1;
    end else begin
      p_last = 3'd7;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    wcode_d   = wcode_q;
    last_d    = last_q;
    idx_d     = idx_q;
    in_pkt_d  = in_pkt_q;
    c_srdy_d  = c_srdy_q;
    c_data_d  = c_data_q;
    c_code_d  = c_code_q;
    err_seq_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;

    if (c_xfer && (c_code_q == `PCC_EOP || c_code_q == `PCC_BADEOP)) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    if (state_q == StSend && c_xfer) begin
      if (!last_byte) begin
        idx_d    = idx_q + 3'd1;
        c_data_d = byte_sel(word_q, idx_q + 3'd1);
        c_code_d = byte_code(wcode_q, idx_q + 3'd1, last_q);
      end else begin
        state_d  = StIdle;
        c_srdy_d = 1'b0;
      end
    end

    // A word accepted on the last-byte edge overrides the return to idle.
    if (p_xfer) begin
      if (p_code == `PCC_SOP) begin
        in_pkt_d  = 1'b1;
        err_seq_d = in_pkt_q;
      end else if (!in_pkt_q) begin
        err_seq_d = 1'b1;
      end else if (p_code != `PCC_DATA) begin
        in_pkt_d = 1'b0;
      end
      if (word_ok) begin
        state_d  = StSend;
        word_d   = p_data;
        wcode_d  = p_code;
        last_d   = p_last;
        idx_d    = 3'd0;
        c_srdy_d = 1'b1;
        c_data_d = byte_sel(p_data, 3'd0);
        c_code_d = byte_code(p_code, 3'd0, p_last);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      word_q    <= '0;
      wcode_q   <= `PCC_DATA;
      last_q    <= 3'd0;
      idx_q     <= 3'd0;
      in_pkt_q  <= 1'b0;
      c_srdy_q  <= 1'b0;
      c_data_q  <= 8'd0;
      c_code_q  <= `PCC_DATA;
      err_seq_q <= 1'b0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      wcode_q   <= wcode_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      in_pkt_q  <= in_pkt_d;
      c_srdy_q  <= c_srdy_d;
      c_data_q  <= c_data_d;
      c_code_q  <= c_code_d;
      err_seq_q <= err_seq_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign c_srdy  = c_srdy_q;
  assign c_data  = c_data_q;
  assign c_code  = c_code_q;
  assign err_seq = err_seq_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule
